// File: rtl/bram1_result_streamer.sv
`timescale 1ns/1ps
// bram1_result_streamer: reads N 64-bit result rows from BRAM1 and streams
// each one as four 16-bit lane beats, lane 0 = row[63:48] first.
// Latency: start accepted in cycle 0, ce_b1_o in cycle 1, first beat valid in cycle 3.
// Backpressure: m_ready_i=0 holds the beat; at most 2 rows are buffered/in flight.
// Ports: clk/reset_n; start_i/row_count_i control; addr/ce/we/d/q_b1 BRAM1 port;
//        m_valid/m_ready/m_data/m_lane/m_last stream; idle/run/done status.
module bram1_result_streamer #(
  parameter int DWIDTH     = 64,
  parameter int LANE_WIDTH = 16,
  parameter int AWIDTH     = 8,
  parameter int MEM_SIZE   = 256
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start_i,
  input  logic [AWIDTH:0]       row_count_i,
  output logic [AWIDTH-1:0]     addr_b1_o,
  output logic                  ce_b1_o,
  output logic                  we_b1_o,
  output logic [DWIDTH-1:0]     d_b1_o,
  input  logic [DWIDTH-1:0]     q_b1_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [LANE_WIDTH-1:0] m_data_o,
  output logic [1:0]            m_lane_o,
  output logic                  m_last_o,
  output logic                  idle_o,
  output logic                  run_o,
  output logic                  done_o
);

  if (DWIDTH != 4 * LANE_WIDTH) begin : g_bad_width
    $error("DWIDTH must equal 4*LANE_WIDTH");
  end
  if (MEM_SIZE > (1 << AWIDTH)) begin : g_bad_depth
    $error("MEM_SIZE exceeds the AWIDTH address space");
  end

  localparam logic [AWIDTH:0] CNT_ONE = (AWIDTH+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state;
  logic [AWIDTH:0] n_rows;     // latched row count
  logic [AWIDTH:0] issued;     // rows read so far; one bit wider so N=MEM_SIZE fits
  logic [AWIDTH:0] popped;     // rows fully emitted
  logic            in_flight;  // a read was issued last cycle, q_b1_i valid now

  // 2-entry row FIFO
  logic [DWIDTH-1:0] fifo_mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [1:0]        lane;

  logic              issue;
  logic              hs;
  logic              pop;
  logic [DWIDTH-1:0] head;

  // Occupancy plus outstanding read must leave room for the returning row.
  assign issue = (state == S_RUN) && (issued < n_rows) &&
                 ((count + {1'b0, in_flight}) < 2'd2);

  assign ce_b1_o   = issue;
  assign addr_b1_o = issue ? issued[AWIDTH-1:0] : '0;
  assign we_b1_o   = 1'b0;
  assign d_b1_o    = '0;

  assign head      = fifo_mem[rd_ptr];
  assign m_valid_o = (count != 2'd0);
  assign m_lane_o  = lane;
  assign m_last_o  = m_valid_o && (lane == 2'd3) && (popped == n_rows - CNT_ONE);
  assign hs        = m_valid_o && m_ready_i;
  assign pop       = hs && (lane == 2'd3);

  always_comb begin
    m_data_o = '0;
    if (m_valid_o) begin
      case (lane)
        2'd0:    m_data_o = head[4*LANE_WIDTH-1:3*LANE_WIDTH];
        2'd1:    m_data_o = head[3*LANE_WIDTH-1:2*LANE_WIDTH];
        2'd2:    m_data_o = head[2*LANE_WIDTH-1:LANE_WIDTH];
        default: m_data_o = head[LANE_WIDTH-1:0];
      endcase
    end
  end

  // Row storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (in_flight) fifo_mem[wr_ptr] <= q_b1_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      idle_o    <= 1'b1;
      run_o     <= 1'b0;
      done_o    <= 1'b0;
      n_rows    <= '0;
      issued    <= '0;
      popped    <= '0;
      in_flight <= 1'b0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      count     <= 2'd0;
      lane      <= 2'd0;
    end else begin
      in_flight <= issue;
      if (issue) issued <= issued + CNT_ONE;
      if (in_flight) wr_ptr <= ~wr_ptr;
      if (hs) lane <= lane + 2'd1;
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        popped <= popped + CNT_ONE;
      end
      count <= count + {1'b0, in_flight} - {1'b0, pop};

      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            n_rows <= row_count_i;
            issued <= '0;
            popped <= '0;
            lane   <= 2'd0;
            idle_o <= 1'b0;
            if (row_count_i == '0) begin
              state  <= S_DONE;
              done_o <= 1'b1;
            end else begin
              state  <= S_RUN;
              run_o  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (hs && m_last_o) begin
            state  <= S_DONE;
            run_o  <= 1'b0;
            done_o <= 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_o <= 1'b0;
          idle_o <= 1'b1;
        end
        default: begin
          state  <= S_IDLE;
          idle_o <= 1'b1;
          run_o  <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bram1_result_streamer.sv
`timescale 1ns/1ps
// Bench for bram1_result_streamer: BRAM1 array model with 1-cycle read,
// expected beats built per row/lane from the memory contents.
module tb_bram1_result_streamer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [8:0]  row_count;
  logic [7:0]  addr;
  logic        ce;
  logic        we;
  logic [63:0] d;
  logic [63:0] q;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [1:0]  m_lane;
  logic        m_last;
  logic        idle;
  logic        run;
  logic        done;

  logic [63:0] mem [256];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (ce) q <= mem[addr];

  bram1_result_streamer dut (
    .clk(clk), .reset_n(reset_n), .start_i(start), .row_count_i(row_count),
    .addr_b1_o(addr), .ce_b1_o(ce), .we_b1_o(we), .d_b1_o(d), .q_b1_i(q),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data),
    .m_lane_o(m_lane), .m_last_o(m_last),
    .idle_o(idle), .run_o(run), .done_o(done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_idle"}, idle, 1);
    chk({tag, "_run_done"}, {run, done}, 0);
    chk({tag, "_stream"}, {m_valid, m_last, m_lane, m_data}, 0);
    chk({tag, "_bram"}, {ce, we, addr}, 0);
    chk({tag, "_wdata"}, d, 0);
  endtask

  // mode 0: ready always 1; mode 1: 1,0,0,1 repeating; mode 2: random.
  // restart_cyc>0 pulses start (with another count) at that cycle.
  task automatic run_xfer(input string tag, input int n, input int mode,
                          input int restart_cyc, input bit timing);
    logic [15:0] exp_d[$];
    logic [1:0]  exp_l[$];
    logic        exp_last[$];
    int issued = 0, completed = 0, beats = 0, last_addr = -1;
    int first_v = -1, last_hs = -1, done_c = -1, done_cnt = 0;
    int limit = 20 * n + 40;
    bit prev_stall = 0;
    logic [15:0] pd;
    logic [1:0]  pl;
    logic        plast;
    bit hs;

    for (int r = 0; r < n; r++)
      for (int l = 0; l < 4; l++) begin
        exp_d.push_back(16'(mem[r] >> (16 * (3 - l))));
        exp_l.push_back(2'(l));
        exp_last.push_back((r == n - 1) && (l == 3));
      end

    @(negedge clk);
    start = 1'b1;
    row_count = 9'(n);
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      start = (c == restart_cyc);
      if (c == restart_cyc) row_count = 9'd2;
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      hs = m_valid && m_ready;

      if (c == 1 && n > 0) chk({tag, "_run_c1"}, {idle, run, done}, 3'b010);
      if (prev_stall) chk({tag, "_hold"}, {m_valid, m_data, m_lane, m_last}, {1'b1, pd, pl, plast});
      if (m_valid && first_v < 0) first_v = c;
      chk({tag, "_tied"}, {we, d}, 0);

      if (ce) begin
        chk({tag, "_ce_room"}, ((issued - completed) < 2) && (issued < n), 1);
        chk({tag, "_addr"}, addr, issued);
        last_addr = addr;
        issued++;
      end

      if (hs) begin
        if (exp_d.size() == 0) chk({tag, "_extra_beat"}, 1, 0);
        else begin
          chk({tag, "_beat"}, {m_data, m_lane, m_last},
              {exp_d.pop_front(), exp_l.pop_front(), exp_last.pop_front()});
        end
        beats++;
        if (m_lane == 2'd3) completed++;
        last_hs = c;
      end

      prev_stall = m_valid && !m_ready;
      pd = m_data;
      pl = m_lane;
      plast = m_last;

      if (done) begin
        done_cnt++;
        if (done_c < 0) done_c = c;
      end
      if (done_c >= 0 && c == done_c + 1) begin
        chk({tag, "_idle_after_done"}, {idle, run, done}, 3'b100);
        break;
      end
    end
    start = 1'b0;

    chk({tag, "_beats"}, beats, 4 * n);
    chk({tag, "_reads"}, issued, n);
    chk({tag, "_done_cycle"}, done_c, (n == 0) ? 1 : last_hs + 1);
    chk({tag, "_done_pulses"}, done_cnt, 1);
    if (n > 0) chk({tag, "_last_addr"}, last_addr, n - 1);
    if (timing && n > 0) begin
      chk({tag, "_first_valid"}, first_v, 3);
      chk({tag, "_last_beat"}, last_hs, 4 * n + 2);
    end
  endtask

  initial begin
    int beats;
    start     = 1'b0;
    row_count = '0;
    m_ready   = 1'b1;
    reset_n   = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_release");

    for (int r = 0; r < 3; r++)
      mem[r] = 64'h0001_0002_0003_0004 + 64'(r) * 64'h0010_0010_0010_0010;
    run_xfer("n3_ready", 3, 0, 0, 1);
    run_xfer("n3_toggle", 3, 1, 0, 0);
    run_xfer("n0", 0, 0, 0, 1);

    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    run_xfer("n256", 256, 0, 0, 1);
    run_xfer("n5_restart", 5, 0, 6, 1);
    run_xfer("n7_random_ready", 7, 2, 0, 0);

    // Reset in the middle of an N=4 run, right after the 5th beat.
    for (int i = 0; i < 4; i++) mem[i] = {$urandom, $urandom};
    m_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    row_count = 9'd4;
    @(negedge clk);
    start = 1'b0;
    beats = 0;
    for (int c = 0; c < 40 && beats < 5; c++) begin
      if (m_valid) beats++;
      if (beats < 5) @(negedge clk);
    end
    chk("midreset_reach5", beats, 5);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_release_quiet", {m_valid, ce, idle}, 3'b001);
    end
    mem[0] = {$urandom, $urandom};
    run_xfer("n1_after_reset", 1, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bram1_result_streamer.md
Name: bram1_result_streamer

Overview:
- Downstream drain stage for the accumulator results in BRAM1.
- On start, reads row_count_i 64-bit result rows from BRAM1 starting at address 0, one row per address.
- Splits each row into four 16-bit lane results and emits them one per beat on a valid/ready stream to the host-side consumer.
- Reports IDLE/RUN/DONE status in the same style as the upstream accessor.

Parameters:
- DWIDTH, 64, BRAM1 row width; must equal 4*LANE_WIDTH.
- LANE_WIDTH, 16, width of one accumulated result.
- AWIDTH, 8, BRAM1 address width.
- MEM_SIZE, 256, BRAM1 depth in rows.

Ports:
- clk  input  1  clock.
- reset_n  input  1  reset, asynchronous, active-low.
- start_i  input  1  start pulse; sampled only in IDLE.
- row_count_i  input  AWIDTH+1  rows to drain, 0..MEM_SIZE; latched on accepted start.
- addr_b1_o  output  AWIDTH  BRAM1 read address.
- ce_b1_o  output  1  BRAM1 chip enable.
- we_b1_o  output  1  BRAM1 write enable; tied 0.
- d_b1_o  output  DWIDTH  BRAM1 write data; tied 0.
- q_b1_i  input  DWIDTH  BRAM1 read data; valid exactly 1 cycle after the ce_b1_o=1 cycle.
- m_valid_o  output  1  stream beat valid.
- m_ready_i  input  1  consumer ready.
- m_data_o  output  LANE_WIDTH  lane result.
- m_lane_o  output  2  lane index 0..3 within the row.
- m_last_o  output  1  final beat of the final row.
- idle_o  output  1  FSM in IDLE.
- run_o  output  1  FSM in RUN.
- done_o  output  1  FSM in DONE.

Behaviour:
- Reset values: idle_o=1; all other outputs 0. Row FIFO empty; all counters 0.
- FSM: IDLE -> RUN on start_i=1 when row_count_i!=0.
- FSM: IDLE -> DONE on start_i=1 when row_count_i==0.
- FSM: RUN -> DONE the cycle after the handshake carrying m_last_o=1.
- FSM: DONE -> IDLE after exactly 1 cycle.
- start_i in RUN or DONE is ignored.
- Read side: a read counter rd_addr runs 0..N-1, where N is the latched count. ce_b1_o=1 and addr_b1_o=rd_addr in a cycle only when all of these hold:
  - state is RUN;
  - rows issued < N;
  - FIFO occupancy + reads in flight < 2.
- Reads are registered: ce_b1_o is first asserted 1 cycle after start is accepted.
- q_b1_i is written into a 2-entry row FIFO in the cycle after each ce_b1_o=1. Overflow is impossible by construction.
- Serializer: pops the FIFO head row and emits 4 beats, lane 0 first. Lane mapping:
  - lane 0 = q[63:48]
  - lane 1 = q[47:32]
  - lane 2 = q[31:16]
  - lane 3 = q[15:0]
  (This matches upstream packing {core1,core2,core3,core4}.)
- A beat transfers when m_valid_o & m_ready_i.
- While m_valid_o=1 and m_ready_i=0, m_data_o, m_lane_o and m_last_o hold stable.
- The FIFO entry is freed on the lane-3 handshake.
- m_last_o=1 only on lane 3 of row N-1.
- Latency: start accepted in cycle 0, ce_b1_o in cycle 1, data captured in cycle 2, first m_valid_o=1 in cycle 3.
- Throughput: with m_ready_i held 1, beats are back-to-back, 4N beats in 4N consecutive cycles, with no bubbles between rows.
- Backpressure: m_ready_i=0 for any duration stalls beats. At most 2 rows are buffered and no reads are issued beyond that.
- N=MEM_SIZE (256): rd_addr reaches 255. The issue counter is AWIDTH+1 bits, so it does not wrap early.
- N=0: no ce_b1_o and no beats; done_o pulses 1 cycle after start.
- reset_n asserted mid-operation: immediate return to reset values. In-flight data and FIFO contents are discarded; no spurious beat after release.

Test Plan:
- BRAM1 rows 0..2 = 0x0001_0002_0003_0004 + row*0x0010_0010_0010_0010; start with N=3, ready=1 -> 12 beats in cycles 3..14, data 0x0001,0x0002,0x0003,0x0004,0x0011,...,0x0024. m_lane_o cycles 0..3; m_last_o only on 0x0024; done_o in cycle 15; idle_o in cycle 16.
- Same data, m_ready_i toggling 1,0,0,1 repeating -> identical 12-beat sequence. Data held stable while ready=0; ce_b1_o never issued with occupancy+in-flight=2.
- N=0 -> ce_b1_o stays 0 and m_valid_o stays 0; done_o=1 for one cycle at cycle 1.
- N=256, random memory, ready=1 -> 1024 beats matching model; addr_b1_o covers 0..255 once each; last read at address 255.
- Pulse start_i again during RUN with N=5 -> ignored; transfer completes with the original count.
- reset_n low after the 5th beat of an N=4 run -> all outputs at reset values asynchronously. Start N=1 after release -> exactly 4 correct beats, no stale data.
